// File: rtl/raster_pkg.sv
// Shared types and constants for the triangle raster front end and the
// barycentric stage that consumes its pixel bundle.
package raster_pkg;

  localparam int unsigned XWIDTH     = 16;
  localparam int unsigned YWIDTH     = 16;
  localparam int unsigned FRAC       = 14;
  localparam int unsigned AINV_WIDTH = 16;
  localparam int unsigned HRES       = 320;
  localparam int unsigned VRES       = 180;
  localparam int unsigned HWIDTH     = $clog2(HRES);
  localparam int unsigned VWIDTH     = $clog2(VRES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [HWIDTH-1:0]          hcount;
    logic [VWIDTH-1:0]          vcount;
    logic [XWIDTH-1:0]          x;
    logic [YWIDTH-1:0]          y;
    logic [2:0][XWIDTH-1:0]     x_tri;
    logic [2:0][YWIDTH-1:0]     y_tri;
    logic [AINV_WIDTH-1:0]      iarea;
    logic                       last;
  } pix_bundle_t;

  typedef struct packed {
    logic [2:0][XWIDTH-1:0]     x_tri;
    logic [2:0][YWIDTH-1:0]     y_tri;
    logic [AINV_WIDTH-1:0]      iarea;
    logic [HWIDTH-1:0]          hmin;
    logic [HWIDTH-1:0]          hmax;
    logic [VWIDTH-1:0]          vmin;
    logic [VWIDTH-1:0]          vmax;
    logic [XWIDTH-1:0]          x_start;
    logic [YWIDTH-1:0]          y_start;
    logic [XWIDTH-1:0]          x_step;
    logic [YWIDTH-1:0]          y_step;
  } tri_desc_t;

endpackage

// File: rtl/tri_raster_scanner_if.sv
// Triangle descriptor handshake in, pixel bundle handshake out.
interface tri_raster_scanner_if;
  import raster_pkg::*;

  logic                       tri_valid_in;
  logic                       tri_ready_out;
  logic [2:0][XWIDTH-1:0]     x_tri_in;
  logic [2:0][YWIDTH-1:0]     y_tri_in;
  logic [AINV_WIDTH-1:0]      iarea_in;
  logic [HWIDTH-1:0]          hmin_in;
  logic [HWIDTH-1:0]          hmax_in;
  logic [VWIDTH-1:0]          vmin_in;
  logic [VWIDTH-1:0]          vmax_in;
  logic [XWIDTH-1:0]          x_start_in;
  logic [YWIDTH-1:0]          y_start_in;
  logic [XWIDTH-1:0]          x_step_in;
  logic [YWIDTH-1:0]          y_step_in;
  logic                       pix_ready_in;
  logic                       pix_valid_out;
  logic [HWIDTH-1:0]          hcount_out;
  logic [VWIDTH-1:0]          vcount_out;
  logic [XWIDTH-1:0]          x_out;
  logic [YWIDTH-1:0]          y_out;
  logic [2:0][XWIDTH-1:0]     x_tri_out;
  logic [2:0][YWIDTH-1:0]     y_tri_out;
  logic [AINV_WIDTH-1:0]      iarea_out;
  logic                       last_out;
  logic                       busy_out;

  modport slave (
    input  tri_valid_in, x_tri_in, y_tri_in, iarea_in, hmin_in, hmax_in,
           vmin_in, vmax_in, x_start_in, y_start_in, x_step_in, y_step_in,
           pix_ready_in,
    output tri_ready_out, pix_valid_out, hcount_out, vcount_out, x_out, y_out,
           x_tri_out, y_tri_out, iarea_out, last_out, busy_out
  );

  modport master (
    output tri_valid_in, x_tri_in, y_tri_in, iarea_in, hmin_in, hmax_in,
           vmin_in, vmax_in, x_start_in, y_start_in, x_step_in, y_step_in,
           pix_ready_in,
    input  tri_ready_out, pix_valid_out, hcount_out, vcount_out, x_out, y_out,
           x_tri_out, y_tri_out, iarea_out, last_out, busy_out
  );

endinterface

// File: rtl/raster_axis_counter.sv
// One scan axis: pixel index plus fixed-point sample accumulator, with
// load / step / restart-to-start controls and an end-of-axis flag.
module raster_axis_counter #(
  parameter int unsigned IW = 9,
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic          restart,
  input  logic [IW-1:0] min_val,
  input  logic [IW-1:0] max_val,
  input  logic [AW-1:0] start_val,
  input  logic [AW-1:0] step_val,
  output logic [IW-1:0] index,
  output logic [AW-1:0] acc,
  output logic          at_max,
  output logic          at_max_nxt_c
);

  logic [IW-1:0] min_q, max_q, index_nxt, max_nxt;
  logic [AW-1:0] base_q, acc_nxt;

  // Accumulation wraps modulo 2^AW; the step is added as-is.
  always_comb begin
    index_nxt = index;
    acc_nxt   = acc;
    max_nxt   = max_q;
    if (load) begin
      index_nxt = min_val;
      acc_nxt   = start_val;
      max_nxt   = max_val;
    end else if (restart) begin
      index_nxt = min_q;
      acc_nxt   = base_q;
    end else if (step) begin
      index_nxt = IW'(index + IW'(1));
      acc_nxt   = AW'(acc + step_val);
    end
    at_max_nxt_c = (index_nxt == max_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index  <= '0;
      acc    <= '0;
      at_max <= 1'b0;
      min_q  <= '0;
      max_q  <= '0;
      base_q <= '0;
    end else begin
      index  <= index_nxt;
      acc    <= acc_nxt;
      at_max <= at_max_nxt_c;
      if (load) begin
        min_q  <= min_val;
        max_q  <= max_val;
        base_q <= start_val;
      end
    end
  end

endmodule

// File: rtl/tri_raster_scanner.sv
// Walks a triangle's clamped pixel bounding box row-major, one pixel per
// accepted cycle, carrying the latched triangle data alongside.
module tri_raster_scanner
  import raster_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  tri_raster_scanner_if.slave  bus
);

  scan_state_t        state, state_nxt;
  tri_desc_t          desc;
  pix_bundle_t        pix;
  logic               accept, cnt_load, col_step, col_restart, row_step, empty;
  logic [HWIDTH-1:0]  hmax_c, hcount;
  logic [VWIDTH-1:0]  vmax_c, vcount;
  logic [XWIDTH-1:0]  x_acc;
  logic [YWIDTH-1:0]  y_acc;
  logic               col_at_max, row_at_max, col_at_max_nxt, row_at_max_nxt;
  logic               tri_ready_q, busy_q, pix_valid_q, last_q;

  // Box clamped to the screen; an empty box never enters SCAN.
  always_comb begin
    hmax_c = (desc.hmax > HWIDTH'(HRES - 1)) ? HWIDTH'(HRES - 1) : desc.hmax;
    vmax_c = (desc.vmax > VWIDTH'(VRES - 1)) ? VWIDTH'(VRES - 1) : desc.vmax;
    empty  = (desc.hmin > hmax_c) || (desc.vmin > vmax_c) ||
             (desc.hmin >= HWIDTH'(HRES)) || (desc.vmin >= VWIDTH'(VRES));
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    cnt_load    = 1'b0;
    col_step    = 1'b0;
    col_restart = 1'b0;
    row_step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.tri_valid_in && tri_ready_q) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (empty) begin
          state_nxt = IDLE;
        end else begin
          cnt_load  = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (pix_valid_q && bus.pix_ready_in) begin
          if (col_at_max && row_at_max) begin
            state_nxt = IDLE;
          end else if (col_at_max) begin
            col_restart = 1'b1;
            row_step    = 1'b1;
          end else begin
            col_step = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      tri_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      tri_ready_q <= (state_nxt == IDLE);
      busy_q      <= (state_nxt != IDLE);
      pix_valid_q <= (state_nxt == SCAN);
      last_q      <= (state_nxt == SCAN) && col_at_max_nxt && row_at_max_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      desc <= '0;
    end else if (accept) begin
      desc.x_tri   <= bus.x_tri_in;
      desc.y_tri   <= bus.y_tri_in;
      desc.iarea   <= bus.iarea_in;
      desc.hmin    <= bus.hmin_in;
      desc.hmax    <= bus.hmax_in;
      desc.vmin    <= bus.vmin_in;
      desc.vmax    <= bus.vmax_in;
      desc.x_start <= bus.x_start_in;
      desc.y_start <= bus.y_start_in;
      desc.x_step  <= bus.x_step_in;
      desc.y_step  <= bus.y_step_in;
    end
  end

  raster_axis_counter #(.IW(HWIDTH), .AW(XWIDTH)) u_col (
    .clk          (clk_in),
    .rst          (rst_in),
    .load         (cnt_load),
    .step         (col_step),
    .restart      (col_restart),
    .min_val      (desc.hmin),
    .max_val      (hmax_c),
    .start_val    (desc.x_start),
    .step_val     (desc.x_step),
    .index        (hcount),
    .acc          (x_acc),
    .at_max       (col_at_max),
    .at_max_nxt_c (col_at_max_nxt)
  );

  raster_axis_counter #(.IW(VWIDTH), .AW(YWIDTH)) u_row (
    .clk          (clk_in),
    .rst          (rst_in),
    .load         (cnt_load),
    .step         (row_step),
    .restart      (1'b0),
    .min_val      (desc.vmin),
    .max_val      (vmax_c),
    .start_val    (desc.y_start),
    .step_val     (desc.y_step),
    .index        (vcount),
    .acc          (y_acc),
    .at_max       (row_at_max),
    .at_max_nxt_c (row_at_max_nxt)
  );

  always_comb begin
    pix.hcount = hcount;
    pix.vcount = vcount;
    pix.x      = x_acc;
    pix.y      = y_acc;
    pix.x_tri  = desc.x_tri;
    pix.y_tri  = desc.y_tri;
    pix.iarea  = desc.iarea;
    pix.last   = last_q;
  end

  assign bus.tri_ready_out = tri_ready_q;
  assign bus.busy_out      = busy_q;
  assign bus.pix_valid_out = pix_valid_q;
  assign bus.hcount_out    = pix.hcount;
  assign bus.vcount_out    = pix.vcount;
  assign bus.x_out         = pix.x;
  assign bus.y_out         = pix.y;
  assign bus.x_tri_out     = pix.x_tri;
  assign bus.y_tri_out     = pix.y_tri;
  assign bus.iarea_out     = pix.iarea;
  assign bus.last_out      = pix.last;

endmodule

// File: tb/tb_tri_raster_scanner.sv
// Bench for tri_raster_scanner: directed scenarios plus random triangles with
// random backpressure, checked against an arithmetic raster model.
module tb_tri_raster_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tri_raster_scanner_if bus ();
  tri_raster_scanner dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  typedef struct packed {
    logic [8:0]  h;
    logic [7:0]  v;
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
  } tb_pix_t;

  tb_pix_t         exp_q[$];
  tb_pix_t         obs_q[$];
  int              tests_run = 0;
  int              tests_failed = 0;
  logic [2:0][15:0] cur_xtri, cur_ytri;
  logic [15:0]     cur_iarea;
  int              first_c, pass_err, hold_err, held_cycles;
  bit              timeout;

  // Expected pixel list: every (h,v) of the clamped box, sample = start + n*step.
  task automatic build_model(input int hmin, input int hmax, input int vmin, input int vmax,
                             input logic [15:0] xs, input logic [15:0] xst,
                             input logic [15:0] ys, input logic [15:0] yst);
    int hmc, vmc;
    tb_pix_t p;
    exp_q.delete();
    hmc = (hmax > 319) ? 319 : hmax;
    vmc = (vmax > 179) ? 179 : vmax;
    if (hmin > hmc || vmin > vmc || hmin >= 320 || vmin >= 180) return;
    for (int v = vmin; v <= vmc; v++) begin
      for (int h = hmin; h <= hmc; h++) begin
        p.h    = 9'(h);
        p.v    = 8'(v);
        p.x    = 16'(32'(xs) + 32'(h - hmin) * 32'(xst));
        p.y    = 16'(32'(ys) + 32'(v - vmin) * 32'(yst));
        p.last = (h == hmc) && (v == vmc);
        exp_q.push_back(p);
      end
    end
  endtask

  // Presents one descriptor and returns #1 after the accepting edge.
  task automatic send_tri(input int hmin, input int hmax, input int vmin, input int vmax,
                          input logic [15:0] xs, input logic [15:0] xst,
                          input logic [15:0] ys, input logic [15:0] yst, output bit to);
    int n = 0;
    cur_xtri  = {16'($urandom), 16'($urandom), 16'($urandom)};
    cur_ytri  = {16'($urandom), 16'($urandom), 16'($urandom)};
    cur_iarea = 16'($urandom);
    bus.x_tri_in   = cur_xtri;
    bus.y_tri_in   = cur_ytri;
    bus.iarea_in   = cur_iarea;
    bus.hmin_in    = 9'(hmin);
    bus.hmax_in    = 9'(hmax);
    bus.vmin_in    = 8'(vmin);
    bus.vmax_in    = 8'(vmax);
    bus.x_start_in = xs;
    bus.x_step_in  = xst;
    bus.y_start_in = ys;
    bus.y_step_in  = yst;
    bus.tri_valid_in = 1'b1;
    to = 1'b0;
    while (bus.tri_ready_out !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (n > 20) begin to = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.tri_valid_in = 1'b0;
    build_model(hmin, hmax, vmin, vmax, xs, xst, ys, yst);
  endtask

  // Drives pix_ready and records accepted pixels until last (or budget expiry).
  task automatic collect(input int max_cycles, input int stall_at, input int stall_len,
                         input bit rand_bp, input bit scramble);
    int c = 0;
    int stall_cnt = 0;
    bit done = 1'b0;
    bit prev_stall = 1'b0;
    tb_pix_t prev, cur;
    obs_q.delete();
    first_c = -1; pass_err = 0; hold_err = 0; held_cycles = 0; timeout = 1'b0;
    prev = '0;
    while (!done) begin
      cur = {bus.hcount_out, bus.vcount_out, bus.x_out, bus.y_out, bus.last_out};
      if (bus.pix_valid_out === 1'b1) begin
        if (first_c < 0) first_c = c;
        if (bus.x_tri_out !== cur_xtri || bus.y_tri_out !== cur_ytri ||
            bus.iarea_out !== cur_iarea) pass_err++;
        if (prev_stall && cur !== prev) hold_err++;
        if (obs_q.size() == stall_at) held_cycles++;
      end
      if (bus.pix_valid_out === 1'b1 && obs_q.size() == stall_at && stall_cnt < stall_len) begin
        bus.pix_ready_in = 1'b0;
        stall_cnt++;
      end else if (rand_bp) begin
        bus.pix_ready_in = ($urandom_range(0, 2) != 0);
      end else begin
        bus.pix_ready_in = 1'b1;
      end
      prev_stall = (bus.pix_valid_out === 1'b1) && !bus.pix_ready_in;
      prev = cur;
      if (bus.pix_valid_out === 1'b1 && bus.pix_ready_in) begin
        obs_q.push_back(cur);
        if (cur.last) done = 1'b1;
      end
      if (scramble) begin
        bus.x_tri_in   = {16'($urandom), 16'($urandom), 16'($urandom)};
        bus.y_tri_in   = {16'($urandom), 16'($urandom), 16'($urandom)};
        bus.iarea_in   = 16'($urandom);
        bus.hmin_in    = 9'($urandom);
        bus.x_start_in = 16'($urandom);
      end
      @(posedge clk); #1;
      c++;
      if (!done && c >= max_cycles) begin timeout = 1'b1; done = 1'b1; end
    end
    bus.pix_ready_in = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.tri_ready_out, bus.pix_valid_out, bus.last_out, bus.busy_out} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got rdy/val/last/busy=%b want 1000",
               {bus.tri_ready_out, bus.pix_valid_out, bus.last_out, bus.busy_out});
    end
    tests_run++;
    if ({bus.hcount_out, bus.vcount_out, bus.x_out, bus.y_out,
         bus.x_tri_out, bus.y_tri_out, bus.iarea_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got h=%0d v=%0d x=%h y=%h iarea=%h want all zero",
               bus.hcount_out, bus.vcount_out, bus.x_out, bus.y_out, bus.iarea_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_handshake();
    bit to;
    int bad = -1;
    send_tri(2, 4, 5, 6, 16'h0100, 16'h0040, 16'h0200, 16'hFFC0, to);
    collect(40, -1, 0, 1'b0, 1'b0);
    tests_run++;
    if (to || timeout) begin tests_failed++; $display("FAIL full_timeout: accept=%0b scan=%0b want 0/0", to, timeout); end
    tests_run++;
    if (first_c != 1) begin tests_failed++; $display("FAIL full_latency: first valid %0d cycles after setup, want 1", first_c); end
    tests_run++;
    if (obs_q.size() != 6) begin tests_failed++; $display("FAIL full_count: got %0d want 6", obs_q.size()); end
    foreach (exp_q[i]) if (bad < 0 && (i >= obs_q.size() || obs_q[i] !== exp_q[i])) bad = i;
    tests_run++;
    if (bad >= 0) begin
      tests_failed++;
      $display("FAIL full_seq: pixel %0d got %h want %h", bad, obs_q[bad], exp_q[bad]);
    end
    tests_run++;
    if (obs_q[3] !== {9'd2, 8'd6, 16'h0100, 16'h01C0, 1'b0}) begin
      tests_failed++;
      $display("FAIL full_pix4: got %h want (2,6,0100,01C0,0)", obs_q[3]);
    end
    tests_run++;
    if ({bus.tri_ready_out, bus.pix_valid_out, bus.busy_out} !== 3'b100) begin
      tests_failed++;
      $display("FAIL full_after: got rdy/val/busy=%b want 100",
               {bus.tri_ready_out, bus.pix_valid_out, bus.busy_out});
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int bad = -1;
    send_tri(2, 4, 5, 6, 16'h0100, 16'h0040, 16'h0200, 16'hFFC0, to);
    collect(60, 1, 3, 1'b0, 1'b0);
    tests_run++;
    if (obs_q.size() != 6 || timeout) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d (timeout=%0b) want 6", obs_q.size(), timeout);
    end
    foreach (exp_q[i]) if (bad < 0 && (i >= obs_q.size() || obs_q[i] !== exp_q[i])) bad = i;
    tests_run++;
    if (bad >= 0) begin
      tests_failed++;
      $display("FAIL bp_seq: pixel %0d got %h want %h", bad, obs_q[bad], exp_q[bad]);
    end
    tests_run++;
    if (held_cycles != 4 || hold_err != 0) begin
      tests_failed++;
      $display("FAIL bp_hold: pixel 2 shown %0d cycles with %0d changes, want 4 and 0", held_cycles, hold_err);
    end
  endtask

  task automatic test_clamp();
    bit to;
    int bad = -1;
    tb_pix_t lastp;
    send_tri(300, 400, 178, 200, 16'h1234, 16'h0010, 16'h4000, 16'h0008, to);
    collect(200, -1, 0, 1'b0, 1'b0);
    tests_run++;
    if (obs_q.size() != 40 || timeout) begin
      tests_failed++;
      $display("FAIL clamp_count: got %0d (timeout=%0b) want 40", obs_q.size(), timeout);
    end
    foreach (exp_q[i]) if (bad < 0 && (i >= obs_q.size() || obs_q[i] !== exp_q[i])) bad = i;
    tests_run++;
    if (bad >= 0) begin
      tests_failed++;
      $display("FAIL clamp_seq: pixel %0d got %h want %h", bad, obs_q[bad], exp_q[bad]);
    end
    lastp = obs_q[$];
    tests_run++;
    if (lastp.h !== 9'd319 || lastp.v !== 8'd179 || lastp.last !== 1'b1) begin
      tests_failed++;
      $display("FAIL clamp_last: got h=%0d v=%0d last=%0b want 319 179 1", lastp.h, lastp.v, lastp.last);
    end
  endtask

  task automatic test_empty();
    int hmins[3] = '{5, 330, 0};
    int hmaxs[3] = '{3, 400, 4};
    int vmins[3] = '{0, 0, 185};
    bit to;
    int valids;
    logic r0, r1;
    for (int k = 0; k < 3; k++) begin
      send_tri(hmins[k], hmaxs[k], vmins[k], vmins[k] + 2, 16'h0, 16'h1, 16'h0, 16'h1, to);
      valids = 0;
      r0 = bus.tri_ready_out;
      if (bus.pix_valid_out !== 1'b0) valids++;
      @(posedge clk); #1;
      r1 = bus.tri_ready_out;
      for (int c = 0; c < 4; c++) begin
        if (bus.pix_valid_out !== 1'b0) valids++;
        @(posedge clk); #1;
      end
      tests_run++;
      if (r0 !== 1'b0 || r1 !== 1'b1 || valids != 0 || exp_q.size() != 0) begin
        tests_failed++;
        $display("FAIL empty_%0d: ready setup/after=%b%b valids=%0d model=%0d want 01 0 0",
                 k, r0, r1, valids, exp_q.size());
      end
    end
  endtask

  task automatic test_single();
    bit to;
    logic [15:0] xs, ys;
    xs = 16'($urandom);
    ys = 16'($urandom);
    send_tri(7, 7, 9, 9, xs, 16'h0123, ys, 16'h0456, to);
    collect(20, -1, 0, 1'b0, 1'b0);
    tests_run++;
    if (obs_q.size() != 1 || obs_q[0] !== {9'd7, 8'd9, xs, ys, 1'b1}) begin
      tests_failed++;
      $display("FAIL single: got n=%0d pix=%h want n=1 pix=%h", obs_q.size(), obs_q[0], {9'd7, 8'd9, xs, ys, 1'b1});
    end
  endtask

  task automatic test_reset_mid_scan();
    bit to;
    int seen = 0;
    int n = 0;
    int bad = -1;
    send_tri(0, 4, 0, 3, 16'h0000, 16'h0100, 16'h0000, 16'h0100, to);
    bus.pix_ready_in = 1'b1;
    while (n < 20) begin
      if (bus.pix_valid_out === 1'b1) begin
        if (seen == 2) break;
        seen++;
      end
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (seen != 2 || {bus.pix_valid_out, bus.tri_ready_out, bus.busy_out} !== 3'b010) begin
      tests_failed++;
      $display("FAIL rst_mid: seen=%0d val/rdy/busy=%b want 2 and 010", seen,
               {bus.pix_valid_out, bus.tri_ready_out, bus.busy_out});
    end
    send_tri(10, 12, 20, 21, 16'h0A00, 16'h0040, 16'h1400, 16'h0040, to);
    collect(40, -1, 0, 1'b0, 1'b0);
    foreach (exp_q[i]) if (bad < 0 && (i >= obs_q.size() || obs_q[i] !== exp_q[i])) bad = i;
    tests_run++;
    if (bad >= 0 || obs_q.size() != 6) begin
      tests_failed++;
      $display("FAIL rst_rescan: n=%0d first bad %0d got %h want %h", obs_q.size(), bad, obs_q[0], exp_q[0]);
    end
  endtask

  task automatic test_wrap_passthrough();
    bit to;
    send_tri(10, 11, 3, 3, 16'h7FC0, 16'h0040, 16'h0100, 16'h0000, to);
    collect(20, -1, 0, 1'b0, 1'b1);
    tests_run++;
    if (obs_q.size() != 2 || obs_q[0].x !== 16'h7FC0 || obs_q[1].x !== 16'h8000) begin
      tests_failed++;
      $display("FAIL wrap_x: n=%0d x=%h,%h want 2 7fc0,8000", obs_q.size(), obs_q[0].x, obs_q[1].x);
    end
    tests_run++;
    if (pass_err != 0) begin
      tests_failed++;
      $display("FAIL passthrough: %0d cycles with tri/iarea not equal to latched, want 0", pass_err);
    end
  endtask

  task automatic test_random();
    bit to;
    int hmin, vmin, bad;
    for (int k = 0; k < 10; k++) begin
      hmin = $urandom_range(0, 325);
      vmin = $urandom_range(0, 182);
      send_tri(hmin, hmin + $urandom_range(0, 5), vmin, vmin + $urandom_range(0, 3),
               16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), to);
      if (exp_q.size() == 0) begin
        @(posedge clk); #1;
        tests_run++;
        if (bus.tri_ready_out !== 1'b1 || bus.pix_valid_out !== 1'b0) begin
          tests_failed++;
          $display("FAIL rand_empty_%0d: rdy=%b val=%b want 1 0", k, bus.tri_ready_out, bus.pix_valid_out);
        end
        continue;
      end
      collect(400, -1, 0, 1'b1, 1'b1);
      bad = -1;
      foreach (exp_q[i]) if (bad < 0 && (i >= obs_q.size() || obs_q[i] !== exp_q[i])) bad = i;
      tests_run++;
      if (to || timeout || bad >= 0 || obs_q.size() != exp_q.size() ||
          pass_err != 0 || hold_err != 0 || first_c != 1) begin
        tests_failed++;
        $display("FAIL rand_%0d: n=%0d want %0d bad=%0d pass=%0d hold=%0d first=%0d timeout=%0b",
                 k, obs_q.size(), exp_q.size(), bad, pass_err, hold_err, first_c, timeout);
      end
    end
  endtask

  initial begin
    bus.tri_valid_in = 1'b0;
    bus.pix_ready_in = 1'b1;
    bus.x_tri_in     = '0;
    bus.y_tri_in     = '0;
    bus.iarea_in     = '0;
    bus.hmin_in      = '0;
    bus.hmax_in      = '0;
    bus.vmin_in      = '0;
    bus.vmax_in      = '0;
    bus.x_start_in   = '0;
    bus.y_start_in   = '0;
    bus.x_step_in    = '0;
    bus.y_step_in    = '0;
    test_reset();
    test_full_handshake();
    test_backpressure();
    test_clamp();
    test_empty();
    test_single();
    test_reset_mid_scan();
    test_wrap_passthrough();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1);
  end

endmodule
